// File: rtl/conv_tree_frame_loader.sv
// Frame loader feeding conv_tree_serializer: packs WORD_W words into an INPUTS_NUM-bit frame
// and swaps it onto PAR_OUT every FRAME_CYCLES clocks. Macro: CONV_TREE_FRAME_LOADER_UNDERRUN_ZERO_EN.
module conv_tree_frame_loader #(
  parameter int INPUTS_NUM   = 256,
  parameter int WORD_W       = 32,
  parameter int FRAME_CYCLES = 128,
  localparam int WORDS       = INPUTS_NUM / WORD_W,
  localparam int CNT_W       = $clog2(WORDS + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [WORD_W-1:0]     IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [INPUTS_NUM-1:0] PAR_OUT,
  output logic                  FRAME_START,
  output logic                  UNDERRUN,
  output logic [CNT_W-1:0]      FILL_CNT
);

  localparam int PC_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  typedef enum logic {FILLING, FULL} fill_state_t;

  fill_state_t           state;
  logic [PC_W-1:0]       pcnt;
  logic [INPUTS_NUM-1:0] fill_p0;
  logic [INPUTS_NUM-1:0] frame_p1;
  logic                  vld_p1;
  logic                  underrun_p1;
  logic [CNT_W-1:0]      fill_cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  ready_q;
  logic                  boundary;
  logic                  xfer;
  logic                  swap;

  assign boundary = (pcnt == PC_W'(FRAME_CYCLES - 1));
  assign xfer     = IN_VALID && ready_q;
  // The boundary decision uses the start-of-cycle state, so a word finishing the frame
  // in the boundary cycle still counts as an underrun.
  assign swap     = boundary && (state == FULL);

  always_comb begin
    cnt_next = fill_cnt;
    if (swap)
      cnt_next = '0;
    else if (xfer)
      cnt_next = fill_cnt + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= FILLING;
      pcnt        <= '0;
      fill_p0     <= '0;
      frame_p1    <= '0;
      vld_p1      <= 1'b0;
      underrun_p1 <= 1'b0;
      fill_cnt    <= '0;
      ready_q     <= 1'b0;
    end else begin
      pcnt        <= boundary ? '0 : pcnt + PC_W'(1);
      vld_p1      <= swap;
      underrun_p1 <= boundary && (state == FILLING);
      fill_cnt    <= cnt_next;
      // Ready is registered from the next count, keeping IN_VALID out of its path.
      ready_q     <= (cnt_next != CNT_W'(WORDS));
      // Fill stage -> frame stage
      if (swap) begin
        frame_p1 <= fill_p0;
        state    <= FILLING;
      end else begin
        if (xfer) begin
          for (int k = 0; k < WORDS; k++) begin
            if (fill_cnt == CNT_W'(k))
              fill_p0[k*WORD_W +: WORD_W] <= IN_DATA;
          end
          if (fill_cnt == CNT_W'(WORDS - 1))
            state <= FULL;
        end
`ifdef CONV_TREE_FRAME_LOADER_UNDERRUN_ZERO_EN
        if (boundary)
          frame_p1 <= '0;
`endif
      end
    end
  end

  assign IN_READY    = ready_q;
  assign PAR_OUT     = frame_p1;
  assign FRAME_START = vld_p1;
  assign UNDERRUN    = underrun_p1;
  assign FILL_CNT    = fill_cnt;

endmodule

// File: tb/tb_conv_tree_frame_loader.sv
// Directed bench for conv_tree_frame_loader with a 64-bit frame, 16-bit words, 8-cycle period:
// a per-cycle vector table plus hand-written reset and streaming sequences.
module tb_conv_tree_frame_loader;

  localparam int INPUTS_NUM   = 64;
  localparam int WORD_W       = 16;
  localparam int FRAME_CYCLES = 8;

  localparam logic [63:0] F1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] F2 = 64'hDDDD_CCCC_BBBB_AAAA;
`ifdef CONV_TREE_FRAME_LOADER_UNDERRUN_ZERO_EN
  localparam logic [63:0] PU = 64'h0;
`else
  localparam logic [63:0] PU = F1;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [WORD_W-1:0]     in_data = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [INPUTS_NUM-1:0] par_out;
  logic                  frame_start;
  logic                  underrun;
  logic [2:0]            fill_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conv_tree_frame_loader #(
    .INPUTS_NUM  (INPUTS_NUM),
    .WORD_W      (WORD_W),
    .FRAME_CYCLES(FRAME_CYCLES)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .IN_DATA    (in_data),
    .IN_VALID   (in_valid),
    .IN_READY   (in_ready),
    .PAR_OUT    (par_out),
    .FRAME_START(frame_start),
    .UNDERRUN   (underrun),
    .FILL_CNT   (fill_cnt)
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic [2:0]  cnt;
    logic        fs;
    logic        ur;
    logic [63:0] par;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [15:0] d, input logic rdy, input logic [2:0] cnt,
                     input logic fs, input logic ur, input logic [63:0] par);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.cnt = cnt; r.fs = fs; r.ur = ur; r.par = par;
    tbl.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        saw_fs;
    logic        rdy_before;
    int          idx;
    int          nfs;
    logic [15:0] w[40];
    logic [63:0] fr[10];

    // Row e = state after e clock edges since reset release (pcnt = e % 8).
    add(0, 16'h0000, 0, 0, 0, 0, 64'h0);
    add(1, 16'h1111, 1, 0, 0, 0, 64'h0);
    add(1, 16'h2222, 1, 1, 0, 0, 64'h0);
    add(1, 16'h3333, 1, 2, 0, 0, 64'h0);
    add(1, 16'h4444, 1, 3, 0, 0, 64'h0);
    for (int i = 5; i <= 7; i++) add(1, 16'hAAAA, 0, 4, 0, 0, 64'h0);
    add(1, 16'hAAAA, 1, 0, 1, 0, F1);
    for (int i = 9; i <= 15; i++) add(0, 16'h0000, 1, 1, 0, 0, F1);
    add(0, 16'h0000, 1, 1, 0, 1, PU);
    for (int i = 17; i <= 20; i++) add(0, 16'h0000, 1, 1, 0, 0, PU);
    add(1, 16'hBBBB, 1, 1, 0, 0, PU);
    add(1, 16'hCCCC, 1, 2, 0, 0, PU);
    add(1, 16'hDDDD, 1, 3, 0, 0, PU);
    add(0, 16'h0000, 0, 4, 0, 1, PU);
    for (int i = 25; i <= 31; i++) add(0, 16'h0000, 0, 4, 0, 0, PU);
    add(0, 16'h0000, 1, 0, 1, 0, F2);
    add(0, 16'h0000, 1, 0, 0, 0, F2);

    repeat (3) @(posedge clk);
    #1;
    check("reset_par", par_out, 64'h0);
    check("reset_cnt", {61'h0, fill_cnt}, 64'h0);
    check("reset_fs", {63'h0, frame_start}, 64'h0);
    check("reset_ur", {63'h0, underrun}, 64'h0);
    check("reset_rdy", {63'h0, in_ready}, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      check($sformatf("row%0d_rdy", i), {63'h0, in_ready}, {63'h0, tbl[i].rdy});
      check($sformatf("row%0d_cnt", i), {61'h0, fill_cnt}, {61'h0, tbl[i].cnt});
      check($sformatf("row%0d_fs", i), {63'h0, frame_start}, {63'h0, tbl[i].fs});
      check($sformatf("row%0d_ur", i), {63'h0, underrun}, {63'h0, tbl[i].ur});
      check($sformatf("row%0d_par", i), par_out, tbl[i].par);
      tick();
    end

    // Asynchronous reset in the middle of a partial fill, with a frame on PAR_OUT.
    in_valid = 1'b1; in_data = 16'h1234; tick();
    in_data = 16'h5678; tick();
    in_valid = 1'b0;
    check("midrst_pre_cnt", {61'h0, fill_cnt}, 64'd2);
    #2 rst = 1'b1;
    #1;
    check("midrst_par", par_out, 64'h0);
    check("midrst_cnt", {61'h0, fill_cnt}, 64'h0);
    check("midrst_fs", {63'h0, frame_start}, 64'h0);
    check("midrst_ur", {63'h0, underrun}, 64'h0);
    check("midrst_rdy", {63'h0, in_ready}, 64'h0);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_rdy", {63'h0, in_ready}, 64'h1);
    saw_fs = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'h0101 * 16'(i + 1);
      saw_fs = saw_fs | frame_start;
      tick();
    end
    in_valid = 1'b0;
    for (int e = 4; e < 20; e++) begin
      saw_fs = saw_fs | frame_start;
      tick();
    end
    check("partial_no_fs", {63'h0, saw_fs}, 64'h0);
    check("partial_cnt", {61'h0, fill_cnt}, 64'd3);
    in_valid = 1'b1; in_data = 16'h0404; tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("partial_done_fs", {63'h0, frame_start}, 64'h1);
    check("partial_done_par", par_out, 64'h0404_0303_0202_0101);

    // Streaming: 10 frames back to back, scoreboard built from the random words.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) w[i] = 16'($urandom);
    for (int f = 0; f < 10; f++) fr[f] = {w[4*f+3], w[4*f+2], w[4*f+1], w[4*f]};
    idx = 0;
    nfs = 0;
    for (int e = 0; e < 88; e++) begin
      if (idx < 40) begin
        in_valid = 1'b1;
        in_data  = w[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (e > 0) begin
        logic exp_fs;
        exp_fs = (e % 8 == 0) && (e >= 8) && (e <= 80);
        check($sformatf("stream%0d_fs", e), {63'h0, frame_start}, {63'h0, exp_fs});
        check($sformatf("stream%0d_ur", e), {63'h0, underrun}, 64'h0);
        if (exp_fs) begin
          check($sformatf("stream_frame%0d", e / 8 - 1), par_out, fr[e/8-1]);
        end
        if (frame_start) nfs++;
      end
      rdy_before = in_ready;
      tick();
      if (in_valid && rdy_before) idx++;
    end
    in_valid = 1'b0;
    check("stream_words", 64'(idx), 64'd40);
    check("stream_frames", 64'(nfs), 64'd10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_tree_frame_loader.md
# conv_tree_frame_loader

Upstream feeder for `conv_tree_serializer`. It accepts parallel data words over a valid/ready handshake and assembles them into a full `INPUTS_NUM`-bit frame in a fill buffer. It presents a stable frame on `PAR_OUT` for exactly `FRAME_CYCLES` clocks, the time the serializer tree needs to drain one frame. At each frame boundary it swaps in the next complete frame, or flags an underrun.

## Interface
- `INPUTS_NUM`, default 256: frame width in bits. Must match the serializer's `INPUTS_NUM` and be a multiple of `WORD_W`.
- `WORD_W`, default 32: input word width. `WORDS = INPUTS_NUM/WORD_W` words per frame.
- `FRAME_CYCLES`, default 128: clocks per frame period. Must be ≥ `WORDS + 2`.
- `CLK` input, 1 bit: single clock. All logic is rising-edge.
- `RESET` input, 1 bit: asynchronous, active-high reset.
- `IN_DATA` input, `WORD_W` bits: input word.
- `IN_VALID` input, 1 bit: `IN_DATA` is valid.
- `IN_READY` output, 1 bit: the loader accepts a word this cycle.
- `PAR_OUT` output, `INPUTS_NUM` bits: frame driven to the serializer's `PAR_IN`. Registered.
- `FRAME_START` output, 1 bit: one-cycle pulse in the first cycle a newly swapped frame is on `PAR_OUT`.
- `UNDERRUN` output, 1 bit: one-cycle pulse when a boundary found no complete frame.
- `FILL_CNT` output, `$clog2(WORDS+1)` bits: number of words currently held in the fill buffer.

## Operation
- **Handshake.** A word transfers on a rising edge when `IN_VALID && IN_READY`.
  - `IN_READY = (FILL_CNT != WORDS)`. It depends on registers only; there is no combinational path from `IN_VALID`.
  - `IN_DATA` must be held stable while `IN_VALID` is high and `IN_READY` is low.
- **Fill order.** Word k of a frame (k = 0..WORDS-1) is written to `fill[k*WORD_W +: WORD_W]`. `FILL_CNT` increments on each transfer.
- **State machine.** The fill side has two states:
  - FILLING: `FILL_CNT < WORDS`.
  - FULL: `FILL_CNT == WORDS`.
  - FILLING goes to FULL on the transfer of word WORDS-1.
  - FULL goes to FILLING only on a boundary swap.
- **Frame counter.** `pcnt` counts 0..`FRAME_CYCLES`-1 and wraps to 0. It runs freely from reset release. The boundary cycle is `pcnt == FRAME_CYCLES-1`.
- **At the boundary, when the start-of-cycle state is FULL:**
  - `PAR_OUT <= fill`.
  - `FILL_CNT <= 0`.
  - `FRAME_START` is 1 in the next cycle.
- **At the boundary, when the state is FILLING:**
  - `UNDERRUN` is 1 in the next cycle.
  - `PAR_OUT` is handled per Configuration.
  - Fill contents and `FILL_CNT` are untouched.
- **Simultaneous events.** A transfer that completes the frame during the boundary cycle is accepted and counted. The boundary decision still uses the start-of-cycle `FILL_CNT`, so that case is an underrun. The completed frame swaps at the next boundary.
- **Outside boundaries.** `PAR_OUT` never changes except at a boundary.
- **Reset values** (asynchronous, applied immediately on `RESET`):
  - `PAR_OUT = 0`, `FRAME_START = 0`, `UNDERRUN = 0`, `FILL_CNT = 0`.
  - `pcnt = 0` and fill buffer = 0.
  - `IN_READY` is 0 while `RESET` is high and 1 in the first cycle after release.
- **Reset mid-operation.** Reset discards any partial frame and the current frame. No `FRAME_START` or `UNDERRUN` pulse is generated by reset.

## Timing
- Latency from the last word of a frame to `PAR_OUT` is up to `FRAME_CYCLES` clocks, since the swap waits for the next boundary.
- The first boundary is the `FRAME_CYCLES`-th rising edge after reset release (`pcnt` 0→`FRAME_CYCLES`-1). The earliest `FRAME_START` comes one cycle later, when `pcnt` = 0.
- `FRAME_START` and `UNDERRUN` are mutually exclusive and only ever assert in cycles with `pcnt == 0`.
- Sustained throughput: one frame per `FRAME_CYCLES`. Upstream can refill within one period because `FRAME_CYCLES ≥ WORDS + 2`.
- `IN_READY` rises in the cycle after a swap.

## Configuration
- Macro: `CONV_TREE_FRAME_LOADER_UNDERRUN_ZERO_EN`.
- Defined: on underrun, `PAR_OUT <= 0`, so the serializer emits an all-zero frame.
- Undefined: on underrun, `PAR_OUT` holds the previous frame, so the serializer repeats it.
- `UNDERRUN` pulses in both builds.

## Test plan
Bench parameters: `INPUTS_NUM=64`, `WORD_W=16`, `FRAME_CYCLES=8`.

- **Reset.** Assert `RESET` mid-fill at `FILL_CNT=2`.
  - Required: all outputs and `FILL_CNT` go to 0 immediately.
  - Required: `IN_READY` is 1 one cycle after release.
  - Required: no `FRAME_START` until a full frame of 4 words is loaded.
- **Single frame.** Send words 0x1111, 0x2222, 0x3333, 0x4444 back-to-back after reset.
  - Required: at the first boundary, `PAR_OUT = 0x4444_3333_2222_1111`.
  - Required: `FRAME_START` pulses once at `pcnt=0`.
- **Backpressure.** Hold `IN_VALID` high with a 5th word 0xAAAA.
  - Required: `IN_READY = 0` while full.
  - Required: 0xAAAA is accepted in the cycle after the swap and lands in fill slot 0.
- **Underrun.** Load no words after frame 1.
  - Required: `UNDERRUN` pulses at the next `pcnt=0`.
  - Required: `PAR_OUT` holds 0x4444_3333_2222_1111, or becomes 0 with `CONV_TREE_FRAME_LOADER_UNDERRUN_ZERO_EN` defined.
- **Boundary race.** Transfer the 4th word exactly at `pcnt=7`.
  - Required: `UNDERRUN` pulses.
  - Required: `FILL_CNT=4`.
  - Required: the frame appears with `FRAME_START` at the following boundary, 8 cycles later.
- **Streaming.** Run 10 consecutive frames at full rate with random data.
  - Required: each `PAR_OUT` matches the scoreboard.
  - Required: exactly one `FRAME_START` per 8 cycles, with no `UNDERRUN`.
